// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// mem_bus_pkg : shared types and constants for the cs/rw single-word memory bus
// Revision    : 1.0
// ============================================================================
package mem_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } bus_state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int ADDR_W_DEFAULT = 16;

  // Bus addresses are byte addresses to 32-bit words; the low two bits are dropped.
  function automatic int word_addr_w(input int addr_w);
    return addr_w - 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_timer.sv
`default_nettype none
// ============================================================================
// mem_bus_timer : loadable down-counter with clear; o_expired while count is 0
// Revision      : 1.0
// ============================================================================
module mem_bus_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mem_bus_initiator.sv
`default_nettype none
// ============================================================================
// mem_bus_initiator : burst command initiator for the cs/rw single-word bus
// Revision          : 1.0
// ============================================================================
module mem_bus_initiator
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              done,
  output logic              err,
  output logic              cs,
  output logic              rw,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ready
);

  localparam int WA_W  = word_addr_w(ADDR_W);
  localparam int TMR_W = $clog2(TIMEOUT);

  bus_state_t r_state;
  bus_state_t w_next;

  logic              r_rw;
  logic [WA_W-1:0]   r_waddr;
  logic [LEN_W-1:0]  r_beats;
  logic              r_err_sticky;
  logic              r_cs;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_done;
  logic              r_err;
  logic [DATA_W-1:0] r_wdata;

  logic w_beat_ok;
  logic w_timeout;
  logic w_expired;
  logic w_tmr_load;
  logic w_unused_addr_lsb;

  assign w_unused_addr_lsb = ^cmd_addr[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_beat_ok = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_next = (cmd_rw == RW_READ) ? ST_ACCESS : ST_WDATA;
        end
      end
      ST_WDATA: begin
        if (wd_valid) begin
          w_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // A completion arriving on the last allowed cycle still counts as a good beat.
        if (bus_ready) begin
          w_beat_ok = 1'b1;
          w_next    = ST_GAP;
        end else if (w_expired) begin
          w_timeout = 1'b1;
          w_next    = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_err_sticky || (r_beats == '0)) begin
          w_next = ST_DONE;
        end else begin
          w_next = (r_rw == RW_READ) ? ST_ACCESS : ST_WDATA;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Loaded with TIMEOUT-1 on entry so cs stays high for exactly TIMEOUT cycles.
  assign w_tmr_load = (w_next == ST_ACCESS) && (r_state != ST_ACCESS);

  mem_bus_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (r_state == ST_DONE),
    .i_load     (w_tmr_load),
    .i_load_val (TMR_W'(TIMEOUT - 1)),
    .i_en       (r_state == ST_ACCESS),
    .o_expired  (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rw         <= RW_WRITE;
      r_waddr      <= '0;
      r_beats      <= '0;
      r_err_sticky <= 1'b0;
      r_cs         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_wdata      <= '0;
    end else begin
      r_cs        <= (w_next == ST_ACCESS);
      r_rsp_valid <= w_beat_ok && (r_rw == RW_READ);
      r_done      <= (w_next == ST_DONE);
      r_err       <= (w_next == ST_DONE) && r_err_sticky;

      if (w_beat_ok && (r_rw == RW_READ)) begin
        r_rsp_data <= bus_rdata;
      end

      if (w_timeout) begin
        r_err_sticky <= 1'b1;
      end else if (r_state == ST_DONE) begin
        r_err_sticky <= 1'b0;
      end

      if ((r_state == ST_IDLE) && cmd_valid) begin
        r_rw    <= cmd_rw;
        r_waddr <= cmd_addr[ADDR_W-1:2];
        r_beats <= cmd_len;
      end

      if ((r_state == ST_WDATA) && wd_valid) begin
        r_wdata <= wd_data;
      end

      // Word address wraps naturally at the top of the address space.
      if (r_state == ST_GAP) begin
        r_waddr <= r_waddr + 1'b1;
        if (r_beats != '0) begin
          r_beats <= r_beats - 1'b1;
        end
      end
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign wd_ready  = (r_state == ST_WDATA);
  assign cs        = r_cs;
  assign rw        = r_rw;
  assign addr      = {r_waddr, 2'b00};
  assign bus_wdata = r_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign done      = r_done;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_mem_bus_initiator : bench for mem_bus_initiator with a RAM-like responder
// Revision             : 1.0
// ============================================================================
module tb_mem_bus_initiator;
  import mem_bus_pkg::*;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 8;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_rw = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              wd_valid = 1'b0;
  logic              wd_ready;
  logic [DATA_W-1:0] wd_data = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              done;
  logic              err;
  logic              cs;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ready;

  always #5 clk = ~clk;

  mem_bus_initiator #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .LEN_W (LEN_W), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk), .reset (reset),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_rw (cmd_rw),
    .cmd_addr (cmd_addr), .cmd_len (cmd_len),
    .wd_valid (wd_valid), .wd_ready (wd_ready), .wd_data (wd_data),
    .rsp_valid (rsp_valid), .rsp_data (rsp_data), .done (done), .err (err),
    .cs (cs), .rw (rw), .addr (addr), .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata), .bus_ready (bus_ready)
  );

  // RAM-like responder: completes on the 3rd cycle of cs high.
  logic [DATA_W-1:0] mem [0:16383];
  int   rcnt = 0;
  logic resp_en = 1'b1;

  assign bus_ready = resp_en && cs && (rcnt == 2);
  assign bus_rdata = mem[addr[ADDR_W-1:2]];

  always @(posedge clk) begin
    if (cs) rcnt <= rcnt + 1;
    else    rcnt <= 0;
    if (bus_ready && (rw == RW_WRITE)) mem[addr[ADDR_W-1:2]] <= bus_wdata;
  end

  typedef struct packed {
    logic             rw;
    logic [15:0]      a;
    logic [7:0]       len;
    logic [3:0][31:0] d;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int exp_cs_run = 3;
  int cs_rises = 0;

  logic [15:0] q_addr [$];
  logic [31:0] q_rd   [$];
  logic        q_err  [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [15:0] a, input logic [7:0] len,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3);
    vec_t v;
    v.rw = r; v.a = a; v.len = len;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    return v;
  endfunction

  task automatic monitor();
    logic        prev_cs = 1'b0;
    int          run = 0;
    logic [15:0] held = '0;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        chk("rsp_in_gap_cs", {31'b0, cs}, 32'd0);
        if (q_rd.size() == 0) chk("rsp_unexpected", {31'b0, rsp_valid}, 32'd0);
        else                  chk("rsp_data", rsp_data, q_rd.pop_front());
      end
      if (done) begin
        if (q_err.size() == 0) chk("done_unexpected", {31'b0, done}, 32'd0);
        else                   chk("done_err", {31'b0, err}, {31'b0, q_err.pop_front()});
      end
      if (cs && !prev_cs) begin
        cs_rises++;
        held = addr;
        if (q_addr.size() == 0) chk("cs_unexpected", {31'b0, cs}, 32'd0);
        else                    chk("beat_addr", {16'b0, addr}, {16'b0, q_addr.pop_front()});
      end else if (cs) begin
        chk("addr_stable", {16'b0, addr}, {16'b0, held});
      end
      if (cs) begin
        run++;
      end else begin
        if (prev_cs && (exp_cs_run != 0)) chk("cs_high_cycles", 32'(run), 32'(exp_cs_run));
        run = 0;
      end
      prev_cs = cs;
    end
  endtask

  task automatic run_cmd(input vec_t v, input int stall_beat, input bit to_mode);
    int          n;
    logic [15:0] held;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("cmd_ready_wait", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_rw = v.rw; cmd_addr = v.a; cmd_len = v.len;
    for (int i = 0; i <= int'(v.len); i++) begin
      if (!to_mode || i == 0) q_addr.push_back((v.a & 16'hFFFC) + 16'(4 * i));
      if (v.rw == RW_READ && !to_mode) q_rd.push_back(v.d[i]);
    end
    q_err.push_back(to_mode);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (v.rw == RW_READ) begin
      @(negedge clk);
      chk("read_cs_latency", {31'b0, cs}, 32'd1);
    end else begin
      for (int i = 0; i <= int'(v.len); i++) begin
        @(negedge clk);
        n = 0;
        while (!wd_ready && n < 100) begin @(negedge clk); n++; end
        chk("wd_ready_wait", {31'b0, wd_ready}, 32'd1);
        if (i == stall_beat) begin
          held = addr;
          repeat (5) begin
            chk("stall_cs", {31'b0, cs}, 32'd0);
            chk("stall_addr", {16'b0, addr}, {16'b0, held});
            @(negedge clk);
          end
        end
        wd_valid = 1'b1; wd_data = v.d[i];
        @(posedge clk); #1;
        wd_valid = 1'b0;
      end
    end
    n = 0;
    while (!done && n < 300) begin @(negedge clk); n++; end
    chk("done_wait", {31'b0, done}, 32'd1);
  endtask

  vec_t vt [6];

  initial begin
    int n, base, rdy_cnt, dn;
    vt[0] = mk(RW_WRITE, 16'h0010, 8'd0, 32'hDEADBEEF, 0, 0, 0);
    vt[1] = mk(RW_READ,  16'h0010, 8'd0, 32'hDEADBEEF, 0, 0, 0);
    vt[2] = mk(RW_WRITE, 16'hFFF8, 8'd3, 32'd1, 32'd2, 32'd3, 32'd4);
    vt[3] = mk(RW_READ,  16'hFFF8, 8'd3, 32'd1, 32'd2, 32'd3, 32'd4);
    vt[4] = mk(RW_WRITE, 16'h0102, 8'd1, 32'hA5A5A5A5, 32'h5A5A5A5A, 0, 0);
    vt[5] = mk(RW_READ,  16'h0103, 8'd1, 32'hA5A5A5A5, 32'h5A5A5A5A, 0, 0);

    fork monitor(); join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_wd_ready",  {31'b0, wd_ready},  32'd0);
    chk("rst_cs",        {31'b0, cs},        32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_done",      {31'b0, done},      32'd0);
    chk("rst_err",       {31'b0, err},       32'd0);
    chk("rst_rw",        {31'b0, rw},        32'd0);
    chk("rst_addr",      {16'b0, addr},      32'd0);
    chk("rst_wdata",     bus_wdata,          32'd0);
    chk("rst_rsp_data",  rsp_data,           32'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_cmd(vt[i], -1, 1'b0);

    // Write source stalls 5 cycles before the second beat.
    run_cmd(mk(RW_WRITE, 16'h0200, 8'd2, 32'h11111111, 32'h22222222, 32'h33333333, 0), 1, 1'b0);
    run_cmd(mk(RW_READ,  16'h0200, 8'd2, 32'h11111111, 32'h22222222, 32'h33333333, 0), -1, 1'b0);

    // Responder silent: timeout abort after exactly TIMEOUT cycles of cs.
    resp_en = 1'b0; exp_cs_run = TIMEOUT;
    run_cmd(mk(RW_READ, 16'h0040, 8'd2, 0, 0, 0, 0), -1, 1'b1);
    @(negedge clk);
    chk("cmd_ready_after_timeout", {31'b0, cmd_ready}, 32'd1);
    resp_en = 1'b1; exp_cs_run = 3;

    // Reset during the second beat of a 4-beat read.
    exp_cs_run = 0;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("cmd_ready_wait", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_rw = RW_READ; cmd_addr = 16'hFFF8; cmd_len = 8'd3;
    q_addr.push_back(16'hFFF8); q_addr.push_back(16'hFFFC); q_rd.push_back(32'd1);
    base = cs_rises;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (cs_rises < base + 2 && n < 100) begin @(negedge clk); n++; end
    chk("second_beat_seen", 32'(cs_rises), 32'(base + 2));
    reset = 1'b1;
    @(negedge clk);
    chk("reset_cs", {31'b0, cs}, 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("reset_addr_q_empty", 32'(q_addr.size()), 32'd0);
    chk("reset_rd_q_empty",   32'(q_rd.size()),   32'd0);
    q_err.delete();
    exp_cs_run = 3;
    run_cmd(mk(RW_READ, 16'hFFF8, 8'd0, 32'd1, 0, 0, 0), -1, 1'b0);

    // Back-to-back reads with cmd_valid held high.
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("cmd_ready_wait", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_rw = RW_READ; cmd_addr = 16'hFFF8; cmd_len = 8'd1;
    q_addr.push_back(16'hFFF8); q_addr.push_back(16'hFFFC);
    q_rd.push_back(32'd1); q_rd.push_back(32'd2); q_err.push_back(1'b0);
    rdy_cnt = 1; dn = 0; n = 0;
    while (dn < 2 && n < 200) begin
      @(posedge clk); #1;
      if (rdy_cnt == 1 && cmd_addr == 16'hFFF8) begin
        cmd_addr = 16'h0000;
        q_addr.push_back(16'h0000); q_addr.push_back(16'h0004);
        q_rd.push_back(32'd3); q_rd.push_back(32'd4); q_err.push_back(1'b0);
      end
      if (rdy_cnt == 2) cmd_valid = 1'b0;
      @(negedge clk);
      n++;
      if (cmd_ready && cmd_valid) rdy_cnt++;
      if (done) dn++;
    end
    cmd_valid = 1'b0;
    chk("b2b_ready_pulses", 32'(rdy_cnt), 32'd2);
    chk("b2b_done_count",   32'(dn),      32'd2);

    repeat (5) @(negedge clk);
    chk("final_addr_q_empty", 32'(q_addr.size()), 32'd0);
    chk("final_rd_q_empty",   32'(q_rd.size()),   32'd0);
    chk("final_err_q_empty",  32'(q_err.size()),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
